if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Parametrised instruction-fetch stage.
- Generates the PC and drives a synchronous-read instruction memory (one-cycle read latency).
- Buffers returned instructions with their PCs in a DEPTH-entry queue, and hands them to ID through a valid/ready handshake.
- Adds redirect (branch/jump) with flush, back-pressure instead of bare write-enables, and configurable width/depth/reset vector.

Parameters:
- XLEN, 32, PC and instruction width.
- IM_AW, 6, instruction-memory word-address width; im_addr = pc[IM_AW+1:2].
- DEPTH, 2, instruction-queue entries (power of two, >=2).
- RESET_PC, 0, PC value loaded on reset.
- NOP_INST, 32'h00000013, value driven on id_inst when the queue is empty.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- im_req  out  1  fetch request this cycle.
- im_addr  out  IM_AW  word address of the request (pc[IM_AW+1:2]).
- im_data  in  XLEN  instruction word, valid the cycle after im_req.
- redirect_valid  in  1  branch/jump taken; overrides everything except rst.
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored (treated as 0).
- id_valid  out  1  queue head holds a valid instruction.
- id_ready  in  1  ID accepts the head this cycle.
- id_inst  out  XLEN  head instruction; NOP_INST when empty.
- id_pc  out  XLEN  PC of head instruction; 0 when empty.
- fetch_pc  out  XLEN  current PC register (debug/observe).

Behaviour:
- Reset (async, any time including mid-transfer):
  - pc=RESET_PC; queue count=0; in-flight flag=0.
  - id_valid=0, id_inst=NOP_INST, id_pc=0, im_req=0.
- State:
  - pc register.
  - inflight flag plus inflight_pc register.
  - Circular queue: rd_ptr, wr_ptr, count 0..DEPTH.
- pop = id_valid & id_ready.
- issue = !redirect_valid & ((count + inflight - pop) < DEPTH).
  - im_req = issue (combinational); im_addr = pc[IM_AW+1:2].
- On issue:
  - pc <= pc + 4, wrapping modulo 2^XLEN.
  - inflight <= 1; inflight_pc <= pc.
  - Otherwise inflight <= 0.
- Response, in the cycle after issue with no redirect:
  - im_data and inflight_pc are written at wr_ptr.
  - count++ (net of pop).
  - Pointers wrap at DEPTH.
- The issue rule guarantees a push never finds the queue full. An assertion fires if push with count==DEPTH and no pop.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Latency and throughput:
  - Request cycle N gives id_valid in cycle N+2.
  - With id_ready held high and DEPTH>=2: one instruction per cycle sustained.
- id_valid = (count != 0). id_inst/id_pc are the head entry. Head is held stable while id_valid & !id_ready.
- Redirect (redirect_valid=1 in cycle N):
  - pc <= {redirect_pc[XLEN-1:2],2'b00}.
  - count, rd_ptr, wr_ptr <= 0; inflight <= 0.
  - Any response arriving in cycle N is discarded.
  - No request in cycle N; first request for the target in N+1.
  - id_valid=0 from N+1 until the target's data is queued (N+3).
  - A pop in cycle N still counts as accepted by ID; flushing it is the consumer's concern.
- Back-to-back redirects: the last one wins; each restarts the sequence above.
- No stall input: back-pressure is solely through id_ready.

Test Plan:
- Reset release, id_ready=1 -> im_addr 0,1,2,... on consecutive cycles; id_valid first high 2 cycles after first im_req. id_pc 0x0,0x4,0x8 paired with matching im_data.
- id_ready=0 for 5 cycles from steady state -> im_req drops once count+inflight reaches DEPTH (2). id_inst/id_pc stay frozen. On id_ready=1, delivery resumes with no lost or duplicated PC.
- redirect_valid pulse with redirect_pc=0x0000004E while queue is full -> im_req=0 that cycle. Next request has im_addr for 0x4C. Old entries never reach ID; id_pc=0x4C appears 3 cycles after the redirect.
- Two redirects on consecutive cycles (0x40 then 0x80) -> only 0x80 is fetched; no entry with id_pc=0x40 is ever valid.
- pc=0xFFFFFFFC (RESET_PC override) -> next fetch_pc=0x00000000; both instructions delivered in order.
- Assert rst while id_valid=1 and a request is in flight -> outputs at reset values immediately (async). After release, fetching restarts at RESET_PC with no stale data.

Source files
------------

// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_queue
// Purpose : PC generation, sync-read IMEM driver and DEPTH-entry fetch queue
//           with redirect/flush and valid/ready hand-off to decode.
// Rev     : 1.0
// ============================================================================
module if_fetch_queue #(
   parameter int               XLEN     = 32,
   parameter int               IM_AW    = 6,
   parameter int               DEPTH    = 2,
   parameter logic [XLEN-1:0]  RESET_PC = '0,
   parameter logic [XLEN-1:0]  NOP_INST = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              rst,
   output logic              im_req,
   output logic [IM_AW-1:0]  im_addr,
   input  logic [XLEN-1:0]   im_data,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [XLEN-1:0]   id_inst,
   output logic [XLEN-1:0]   id_pc,
   output logic [XLEN-1:0]   fetch_pc
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] c_DEPTH = (CNT_W+1)'(DEPTH);

   logic [XLEN-1:0]  r_pc;
   logic             r_inflight;
   logic [XLEN-1:0]  r_inflight_pc;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;
   logic [XLEN-1:0]  r_q_inst [DEPTH];
   logic [XLEN-1:0]  r_q_pc   [DEPTH];

   logic             w_pop;
   logic             w_push;
   logic             w_issue;
   logic [CNT_W:0]   w_occ;
   logic             w_unused;

   assign w_unused = &{1'b0, redirect_pc[1:0]};

   assign id_valid = (r_count != '0);
   assign w_pop    = id_valid & id_ready;
   assign w_push   = r_inflight & ~redirect_valid;

   // Occupancy counts the in-flight slot so a response always has room.
   assign w_occ   = {1'b0, r_count} + (CNT_W+1)'(r_inflight) - (CNT_W+1)'(w_pop);
   assign w_issue = ~redirect_valid & (w_occ < c_DEPTH);

   assign im_req   = w_issue & ~rst;
   assign im_addr  = r_pc[IM_AW+1:2];
   assign fetch_pc = r_pc;
   assign id_inst  = id_valid ? r_q_inst[r_rd_ptr] : NOP_INST;
   assign id_pc    = id_valid ? r_q_pc[r_rd_ptr]   : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc          <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_count       <= '0;
      end else if (redirect_valid) begin
         r_pc       <= {redirect_pc[XLEN-1:2], 2'b00};
         r_inflight <= 1'b0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_pc          <= r_pc + XLEN'(4);
            r_inflight_pc <= r_pc;
         end
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   // Queue storage needs no reset: entries are only visible while counted.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_inst[r_wr_ptr] <= im_data;
         r_q_pc[r_wr_ptr]   <= r_inflight_pc;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(w_push && !w_pop && r_count == CNT_W'(DEPTH)));

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// Directed bench for if_fetch_queue: streaming, back-pressure, redirects,
// PC wrap (second instance) and asynchronous reset.
module tb_if_fetch_queue;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        id_ready = 1'b1;
   logic        im_req, id_valid;
   logic [5:0]  im_addr;
   logic [31:0] im_data = '0, id_inst, id_pc, fetch_pc;

   logic        b_redirect_valid = 1'b0;
   logic [31:0] b_redirect_pc = '0;
   logic        b_id_ready = 1'b1;
   logic        b_im_req, b_id_valid;
   logic [5:0]  b_im_addr;
   logic [31:0] b_im_data = '0, b_id_inst, b_id_pc, b_fetch_pc;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] fa(input logic [5:0] a);
      return 32'hAB00_0000 | {26'b0, a};
   endfunction

   function automatic logic [31:0] fb(input logic [5:0] a);
      return 32'hCD00_0000 | {26'b0, a};
   endfunction

   always @(posedge clk) if (im_req) im_data <= fa(im_addr);
   always @(posedge clk) if (b_im_req) b_im_data <= fb(b_im_addr);

   if_fetch_queue dut (
      .clk(clk), .rst(rst), .im_req(im_req), .im_addr(im_addr), .im_data(im_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc),
      .fetch_pc(fetch_pc)
   );

   if_fetch_queue #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
      .clk(clk), .rst(rst), .im_req(b_im_req), .im_addr(b_im_addr), .im_data(b_im_data),
      .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
      .id_valid(b_id_valid), .id_ready(b_id_ready), .id_inst(b_id_inst), .id_pc(b_id_pc),
      .fetch_pc(b_fetch_pc)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      redirect_valid = 1'b0;
      id_ready = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      #1;
      n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL reset_id_valid got %b want 0", id_valid); end
      n_vec++; if (im_req !== 1'b0) begin n_err++; $display("FAIL reset_im_req got %b want 0", im_req); end
      n_vec++; if (id_inst !== NOP) begin n_err++; $display("FAIL reset_id_inst got %h want %h", id_inst, NOP); end
      n_vec++; if (id_pc !== 32'h0) begin n_err++; $display("FAIL reset_id_pc got %h want 0", id_pc); end
      n_vec++; if (fetch_pc !== 32'h0) begin n_err++; $display("FAIL reset_fetch_pc got %h want 0", fetch_pc); end
   endtask

   task automatic test_stream();
      do_reset();
      for (int k = 0; k < 6; k++) begin
         #1;
         n_vec++; if (im_req !== 1'b1 || im_addr !== 6'(k)) begin
            n_err++; $display("FAIL stream_req c%0d got req=%b addr=%0d want req=1 addr=%0d", k, im_req, im_addr, k);
         end
         if (k < 2) begin
            n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL stream_early_valid c%0d got %b want 0", k, id_valid); end
         end else begin
            n_vec++; if (id_valid !== 1'b1 || id_pc !== 32'(4*(k-2)) || id_inst !== fa(6'(k-2))) begin
               n_err++; $display("FAIL stream_head c%0d got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                                 k, id_valid, id_pc, id_inst, 32'(4*(k-2)), fa(6'(k-2)));
            end
         end
         step();
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int k = 0; k < 6; k++) step();
      id_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         n_vec++; if (im_req !== 1'b0) begin n_err++; $display("FAIL bp_req c%0d got %b want 0", k, im_req); end
         n_vec++; if (id_valid !== 1'b1 || id_pc !== 32'h10 || id_inst !== fa(6'd4)) begin
            n_err++; $display("FAIL bp_hold c%0d got v=%b pc=%h inst=%h want v=1 pc=10 inst=%h", k, id_valid, id_pc, id_inst, fa(6'd4));
         end
         step();
      end
      id_ready = 1'b1;
      for (int r = 0; r < 4; r++) begin
         #1;
         n_vec++; if (id_valid !== 1'b1 || id_pc !== 32'(16 + 4*r) || id_inst !== fa(6'(4 + r))) begin
            n_err++; $display("FAIL bp_resume r%0d got v=%b pc=%h want v=1 pc=%h", r, id_valid, id_pc, 32'(16 + 4*r));
         end
         n_vec++; if (im_req !== 1'b1 || im_addr !== 6'(6 + r)) begin
            n_err++; $display("FAIL bp_resume_req r%0d got req=%b addr=%0d want req=1 addr=%0d", r, im_req, im_addr, 6 + r);
         end
         step();
      end
   endtask

   task automatic test_redirect_full();
      do_reset();
      for (int k = 0; k < 4; k++) step();
      id_ready = 1'b0;
      step();
      step();
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_004E;
      #1;
      n_vec++; if (im_req !== 1'b0) begin n_err++; $display("FAIL redir_req got %b want 0", im_req); end
      step();
      redirect_valid = 1'b0;
      id_ready = 1'b1;
      for (int r = 1; r <= 4; r++) begin
         #1;
         if (r <= 2) begin
            n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush r%0d got valid=%b pc=%h want valid=0", r, id_valid, id_pc); end
         end else begin
            n_vec++; if (id_valid !== 1'b1 || id_pc !== 32'(32'h4C + 4*(r-3)) || id_inst !== fa(6'(19 + r - 3))) begin
               n_err++; $display("FAIL redir_target r%0d got v=%b pc=%h inst=%h want v=1 pc=%h", r, id_valid, id_pc, id_inst, 32'(32'h4C + 4*(r-3)));
            end
         end
         if (r == 1) begin
            n_vec++; if (im_req !== 1'b1 || im_addr !== 6'h13) begin
               n_err++; $display("FAIL redir_first_req got req=%b addr=%h want req=1 addr=13", im_req, im_addr);
            end
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int k = 0; k < 3; k++) step();
      redirect_valid = 1'b1;
      redirect_pc = 32'h40;
      #1;
      n_vec++; if (im_req !== 1'b0) begin n_err++; $display("FAIL b2b_req0 got %b want 0", im_req); end
      step();
      redirect_pc = 32'h80;
      #1;
      n_vec++; if (im_req !== 1'b0) begin n_err++; $display("FAIL b2b_req1 got %b want 0", im_req); end
      step();
      redirect_valid = 1'b0;
      #1;
      n_vec++; if (im_req !== 1'b1 || im_addr !== 6'h20) begin
         n_err++; $display("FAIL b2b_addr got req=%b addr=%h want req=1 addr=20", im_req, im_addr);
      end
      step();
      #1;
      n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL b2b_gap got valid=%b pc=%h want 0", id_valid, id_pc); end
      step();
      for (int r = 0; r < 4; r++) begin
         #1;
         n_vec++; if (id_valid !== 1'b1 || id_pc !== 32'(32'h80 + 4*r)) begin
            n_err++; $display("FAIL b2b_seq r%0d got v=%b pc=%h want v=1 pc=%h", r, id_valid, id_pc, 32'(32'h80 + 4*r));
         end
         step();
      end
   endtask

   task automatic test_pc_wrap();
      do_reset();
      #1;
      n_vec++; if (b_fetch_pc !== 32'hFFFF_FFFC || b_im_addr !== 6'h3F || b_im_req !== 1'b1) begin
         n_err++; $display("FAIL wrap_start got pc=%h addr=%h req=%b want pc=fffffffc addr=3f req=1", b_fetch_pc, b_im_addr, b_im_req);
      end
      step();
      #1;
      n_vec++; if (b_fetch_pc !== 32'h0 || b_im_addr !== 6'h0) begin
         n_err++; $display("FAIL wrap_pc got pc=%h addr=%h want pc=0 addr=0", b_fetch_pc, b_im_addr);
      end
      step();
      #1;
      n_vec++; if (b_id_valid !== 1'b1 || b_id_pc !== 32'hFFFF_FFFC || b_id_inst !== fb(6'h3F)) begin
         n_err++; $display("FAIL wrap_first got v=%b pc=%h inst=%h want v=1 pc=fffffffc inst=%h", b_id_valid, b_id_pc, b_id_inst, fb(6'h3F));
      end
      step();
      #1;
      n_vec++; if (b_id_valid !== 1'b1 || b_id_pc !== 32'h0 || b_id_inst !== fb(6'h0)) begin
         n_err++; $display("FAIL wrap_second got v=%b pc=%h inst=%h want v=1 pc=0 inst=%h", b_id_valid, b_id_pc, b_id_inst, fb(6'h0));
      end
      step();
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int k = 0; k < 3; k++) step();
      #2;
      rst = 1'b1;
      #1;
      n_vec++; if (id_valid !== 1'b0 || im_req !== 1'b0 || id_inst !== NOP || id_pc !== 32'h0 || fetch_pc !== 32'h0) begin
         n_err++; $display("FAIL async_rst got v=%b req=%b inst=%h pc=%h fpc=%h want 0/0/%h/0/0",
                           id_valid, im_req, id_inst, id_pc, fetch_pc, NOP);
      end
      step();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         n_vec++; if (im_addr !== 6'(k) || im_req !== 1'b1) begin
            n_err++; $display("FAIL async_restart_req c%0d got req=%b addr=%0d want req=1 addr=%0d", k, im_req, im_addr, k);
         end
         if (k < 2) begin
            n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL async_stale c%0d got valid=%b pc=%h want 0", k, id_valid, id_pc); end
         end else begin
            n_vec++; if (id_valid !== 1'b1 || id_pc !== 32'(4*(k-2)) || id_inst !== fa(6'(k-2))) begin
               n_err++; $display("FAIL async_restart_head c%0d got v=%b pc=%h inst=%h want pc=%h", k, id_valid, id_pc, id_inst, 32'(4*(k-2)));
            end
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_full();
      test_back_to_back();
      test_pc_wrap();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
